// File: rtl/res_station_issue.sv
// res_station_issue
//   Unified reservation station with wakeup and in-order-priority select.
//   Renamed instructions enter through a valid/ready dispatch port. They wait
//   in a row until both source operands are ready and their functional unit is
//   free, and then leave through a registered single-issue bundle.
//
// Ports
//   clk, rst_n        single clock (posedge), asynchronous active-low reset
//   disp_valid/ready  dispatch handshake; a transfer happens when both are high
//   disp_op/pd/ps1/ps2/rob, disp_s1_rdy/disp_s2_rdy
//                     renamed instruction fields and source-ready flags
//   wb_valid, wb_tag0/wb_tag1
//                     two completion broadcast lanes used for operand wakeup
//   fu_busy           per-FU busy flags (bit0 ALU0, bit1 ALU1, bit2 MEM)
//   flush             synchronous clear of all rows and of the issue slot
//   iss_*             registered issue bundle (iss_fu: 0 ALU0, 1 ALU1, 2 MEM)
//   occupancy         number of rows in use
module res_station_issue #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TAG_W = 6,
    parameter int unsigned ROB_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [6:0]       disp_op,
    input  logic [TAG_W-1:0] disp_pd,
    input  logic [TAG_W-1:0] disp_ps1,
    input  logic [TAG_W-1:0] disp_ps2,
    input  logic [ROB_W-1:0] disp_rob,
    input  logic             disp_s1_rdy,
    input  logic             disp_s2_rdy,
    input  logic [1:0]       wb_valid,
    input  logic [TAG_W-1:0] wb_tag0,
    input  logic [TAG_W-1:0] wb_tag1,
    input  logic [2:0]       fu_busy,
    input  logic             flush,
    output logic             iss_valid,
    output logic [6:0]       iss_op,
    output logic [TAG_W-1:0] iss_pd,
    output logic [TAG_W-1:0] iss_ps1,
    output logic [TAG_W-1:0] iss_ps2,
    output logic [ROB_W-1:0] iss_rob,
    output logic [1:0]       iss_fu,
    output logic [4:0]       occupancy
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Row control state (reset) and row payload (no reset; only read while
    // the row is in use).
    logic [DEPTH-1:0] row_in_use;
    logic [DEPTH-1:0] row_s1_rdy;
    logic [DEPTH-1:0] row_s2_rdy;
    logic [6:0]       row_op  [DEPTH];
    logic [TAG_W-1:0] row_pd  [DEPTH];
    logic [TAG_W-1:0] row_ps1 [DEPTH];
    logic [TAG_W-1:0] row_ps2 [DEPTH];
    logic [ROB_W-1:0] row_rob [DEPTH];
    logic [1:0]       row_fu  [DEPTH];

    logic [DEPTH-1:0] eligible;
    logic [3:0]       busy_ext;
    logic             sel_valid;
    logic [IDX_W-1:0] sel_idx;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             disp_fire;
    logic [1:0]       disp_fu;

    // True when either valid broadcast lane carries this tag. Equal tags on
    // both lanes simply OR together.
    function automatic logic wb_hit(input logic [TAG_W-1:0] tag,
                                    input logic [1:0]       vld,
                                    input logic [TAG_W-1:0] t0,
                                    input logic [TAG_W-1:0] t1);
        return (vld[0] && (tag == t0)) || (vld[1] && (tag == t1));
    endfunction

    assign disp_ready = rst_n && !flush && (32'(occupancy) < DEPTH);
    assign disp_fire  = disp_valid && disp_ready && free_found;

    // Loads and stores go to MEM; everything else is split across the two
    // ALUs by ROB index parity.
    assign disp_fu = ((disp_op == 7'b0000011) || (disp_op == 7'b0100011))
                     ? 2'd2 : {1'b0, disp_rob[0]};

    // Encoding 3 never occurs; treat it as busy so it can never be selected.
    assign busy_ext = {1'b1, fu_busy};

    // Eligibility and select work only on state registered at the start of the
    // cycle, so a row woken or dispatched at an edge cannot issue until the
    // following edge.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            eligible[i] = row_in_use[i] && row_s1_rdy[i] && row_s2_rdy[i]
                          && !busy_ext[row_fu[i]];
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (eligible[i] && !sel_valid) begin
                sel_valid = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // A row being issued still reads in_use=1 here, so the dispatch in the
    // same cycle always lands in a different row.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!row_in_use[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_in_use <= '0;
            row_s1_rdy <= '0;
            row_s2_rdy <= '0;
            occupancy  <= '0;
            iss_valid  <= 1'b0;
            iss_op     <= '0;
            iss_pd     <= '0;
            iss_ps1    <= '0;
            iss_ps2    <= '0;
            iss_rob    <= '0;
            iss_fu     <= '0;
        end else if (flush) begin
            row_in_use <= '0;
            occupancy  <= '0;
            iss_valid  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (row_in_use[i]) begin
                    if (wb_hit(row_ps1[i], wb_valid, wb_tag0, wb_tag1))
                        row_s1_rdy[i] <= 1'b1;
                    if (wb_hit(row_ps2[i], wb_valid, wb_tag0, wb_tag1))
                        row_s2_rdy[i] <= 1'b1;
                end
            end

            if (sel_valid) begin
                row_in_use[sel_idx] <= 1'b0;
                iss_valid <= 1'b1;
                iss_op    <= row_op[sel_idx];
                iss_pd    <= row_pd[sel_idx];
                iss_ps1   <= row_ps1[sel_idx];
                iss_ps2   <= row_ps2[sel_idx];
                iss_rob   <= row_rob[sel_idx];
                iss_fu    <= row_fu[sel_idx];
            end else begin
                iss_valid <= 1'b0;
            end

            // Free rows never collide with the wakeup loop above (in_use=0),
            // so these writes are the only ones to row free_idx.
            if (disp_fire) begin
                row_in_use[free_idx] <= 1'b1;
                row_s1_rdy[free_idx] <= disp_s1_rdy
                                        || wb_hit(disp_ps1, wb_valid, wb_tag0, wb_tag1);
                row_s2_rdy[free_idx] <= disp_s2_rdy
                                        || wb_hit(disp_ps2, wb_valid, wb_tag0, wb_tag1);
            end

            occupancy <= occupancy + 5'(disp_fire) - 5'(sel_valid);
        end
    end

    always_ff @(posedge clk) begin
        if (disp_fire) begin
            row_op[free_idx]  <= disp_op;
            row_pd[free_idx]  <= disp_pd;
            row_ps1[free_idx] <= disp_ps1;
            row_ps2[free_idx] <= disp_ps2;
            row_rob[free_idx] <= disp_rob;
            row_fu[free_idx]  <= disp_fu;
        end
    end

endmodule

// File: tb/tb_res_station_issue.sv
// Directed testbench for res_station_issue: one task per scenario, each doing
// its own inline comparisons against hand-computed values.
module tb_res_station_issue;

    logic       clk;
    logic       rst_n;
    logic       disp_valid;
    logic       disp_ready;
    logic [6:0] disp_op;
    logic [5:0] disp_pd, disp_ps1, disp_ps2;
    logic [3:0] disp_rob;
    logic       disp_s1_rdy, disp_s2_rdy;
    logic [1:0] wb_valid;
    logic [5:0] wb_tag0, wb_tag1;
    logic [2:0] fu_busy;
    logic       flush;
    logic       iss_valid;
    logic [6:0] iss_op;
    logic [5:0] iss_pd, iss_ps1, iss_ps2;
    logic [3:0] iss_rob;
    logic [1:0] iss_fu;
    logic [4:0] occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    res_station_issue #(.DEPTH(16), .TAG_W(6), .ROB_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_op(disp_op), .disp_pd(disp_pd), .disp_ps1(disp_ps1),
        .disp_ps2(disp_ps2), .disp_rob(disp_rob),
        .disp_s1_rdy(disp_s1_rdy), .disp_s2_rdy(disp_s2_rdy),
        .wb_valid(wb_valid), .wb_tag0(wb_tag0), .wb_tag1(wb_tag1),
        .fu_busy(fu_busy), .flush(flush),
        .iss_valid(iss_valid), .iss_op(iss_op), .iss_pd(iss_pd),
        .iss_ps1(iss_ps1), .iss_ps2(iss_ps2), .iss_rob(iss_rob),
        .iss_fu(iss_fu), .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic [6:0] op, input logic [5:0] pd,
                            input logic [5:0] ps1, input logic s1,
                            input logic [5:0] ps2, input logic s2,
                            input logic [3:0] rob);
        disp_valid  = 1'b1;
        disp_op     = op;
        disp_pd     = pd;
        disp_ps1    = ps1;
        disp_s1_rdy = s1;
        disp_ps2    = ps2;
        disp_s2_rdy = s2;
        disp_rob    = rob;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL reset_iss_valid: got %0b want 0", iss_valid); end
        n_checks++; if (occupancy !== 5'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        n_checks++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL reset_disp_ready: got %0b want 0", disp_ready); end
        n_checks++; if (iss_pd !== 6'd0) begin n_fail++; $display("FAIL reset_iss_pd: got %0d want 0", iss_pd); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %0b want 1", disp_ready); end
    endtask

    task automatic test_basic();
        set_disp(7'b0110011, 6'd33, 6'd1, 1'b1, 6'd2, 1'b1, 4'd4);
        tick();
        disp_valid = 1'b0;
        n_checks++; if (occupancy !== 5'd1) begin n_fail++; $display("FAIL basic_occ1: got %0d want 1", occupancy); end
        n_checks++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL basic_not_yet: got %0b want 0", iss_valid); end
        tick();
        n_checks++; if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL basic_iss_valid: got %0b want 1", iss_valid); end
        n_checks++; if (iss_pd !== 6'd33) begin n_fail++; $display("FAIL basic_iss_pd: got %0d want 33", iss_pd); end
        n_checks++; if (iss_fu !== 2'd0) begin n_fail++; $display("FAIL basic_iss_fu: got %0d want 0", iss_fu); end
        n_checks++; if (iss_rob !== 4'd4) begin n_fail++; $display("FAIL basic_iss_rob: got %0d want 4", iss_rob); end
        n_checks++; if (iss_op !== 7'b0110011) begin n_fail++; $display("FAIL basic_iss_op: got %b want 0110011", iss_op); end
        n_checks++; if ({iss_ps1, iss_ps2} !== {6'd1, 6'd2}) begin n_fail++; $display("FAIL basic_iss_ps: got %0d/%0d want 1/2", iss_ps1, iss_ps2); end
        n_checks++; if (occupancy !== 5'd0) begin n_fail++; $display("FAIL basic_occ0: got %0d want 0", occupancy); end
        tick();
        n_checks++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL basic_iss_drop: got %0b want 0", iss_valid); end
    endtask

    task automatic test_wakeup();
        set_disp(7'b0110011, 6'd10, 6'd40, 1'b0, 6'd3, 1'b1, 4'd5);
        tick();
        disp_valid = 1'b0;
        tick();
        n_checks++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL wake_waiting: got %0b want 0", iss_valid); end
        wb_valid = 2'b01;
        wb_tag0  = 6'd40;
        tick();
        wb_valid = 2'b00;
        n_checks++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL wake_edge_no_issue: got %0b want 0", iss_valid); end
        tick();
        n_checks++; if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL wake_issue: got %0b want 1", iss_valid); end
        n_checks++; if (iss_pd !== 6'd10) begin n_fail++; $display("FAIL wake_iss_pd: got %0d want 10", iss_pd); end
        n_checks++; if (iss_fu !== 2'd1) begin n_fail++; $display("FAIL wake_iss_fu: got %0d want 1", iss_fu); end
        n_checks++; if (occupancy !== 5'd0) begin n_fail++; $display("FAIL wake_occ: got %0d want 0", occupancy); end
    endtask

    task automatic test_same_cycle_wake();
        set_disp(7'b0010011, 6'd20, 6'd5, 1'b1, 6'd50, 1'b0, 4'd2);
        wb_valid = 2'b10;
        wb_tag0  = 6'd0;
        wb_tag1  = 6'd50;
        tick();
        disp_valid = 1'b0;
        wb_valid   = 2'b00;
        n_checks++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL samewake_early: got %0b want 0", iss_valid); end
        tick();
        n_checks++; if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL samewake_issue: got %0b want 1", iss_valid); end
        n_checks++; if (iss_pd !== 6'd20) begin n_fail++; $display("FAIL samewake_pd: got %0d want 20", iss_pd); end
        tick();
    endtask

    task automatic test_priority();
        fu_busy = 3'b001;
        set_disp(7'b0110011, 6'd1, 6'd0, 1'b1, 6'd0, 1'b1, 4'd0);
        tick();
        set_disp(7'b0110011, 6'd2, 6'd60, 1'b0, 6'd0, 1'b1, 4'd2);
        tick();
        set_disp(7'b0110011, 6'd3, 6'd61, 1'b0, 6'd0, 1'b1, 4'd4);
        tick();
        set_disp(7'b0110011, 6'd4, 6'd0, 1'b1, 6'd0, 1'b1, 4'd6);
        tick();
        disp_valid = 1'b0;
        n_checks++; if (occupancy !== 5'd4) begin n_fail++; $display("FAIL prio_occ4: got %0d want 4", occupancy); end
        n_checks++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL prio_alu0_busy: got %0b want 0", iss_valid); end
        fu_busy = 3'b000;
        tick();
        n_checks++; if ({iss_valid, iss_pd} !== {1'b1, 6'd1}) begin n_fail++; $display("FAIL prio_row0_first: got v=%0b pd=%0d want v=1 pd=1", iss_valid, iss_pd); end
        tick();
        n_checks++; if ({iss_valid, iss_pd} !== {1'b1, 6'd4}) begin n_fail++; $display("FAIL prio_row3_next: got v=%0b pd=%0d want v=1 pd=4", iss_valid, iss_pd); end
        n_checks++; if (occupancy !== 5'd2) begin n_fail++; $display("FAIL prio_occ2: got %0d want 2", occupancy); end
        fu_busy = 3'b100;
        set_disp(7'b0000011, 6'd7, 6'd0, 1'b1, 6'd0, 1'b1, 4'd3);
        tick();
        disp_valid = 1'b0;
        n_checks++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL prio_mem_blocked1: got %0b want 0", iss_valid); end
        tick();
        n_checks++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL prio_mem_blocked2: got %0b want 0", iss_valid); end
        fu_busy = 3'b000;
        tick();
        n_checks++; if ({iss_valid, iss_pd, iss_fu} !== {1'b1, 6'd7, 2'd2}) begin n_fail++; $display("FAIL prio_mem_issue: got v=%0b pd=%0d fu=%0d want v=1 pd=7 fu=2", iss_valid, iss_pd, iss_fu); end
        n_checks++; if (occupancy !== 5'd2) begin n_fail++; $display("FAIL prio_mem_occ: got %0d want 2", occupancy); end
    endtask

    task automatic test_flush();
        // Rows 1 and 2 are still waiting on tags 60/61.
        set_disp(7'b0110011, 6'd8, 6'd62, 1'b0, 6'd0, 1'b1, 4'd0);
        tick();
        tick();
        set_disp(7'b0110011, 6'd9, 6'd0, 1'b1, 6'd0, 1'b1, 4'd0);
        tick();
        n_checks++; if (occupancy !== 5'd5) begin n_fail++; $display("FAIL flush_occ5: got %0d want 5", occupancy); end
        set_disp(7'b0110011, 6'd13, 6'd0, 1'b1, 6'd0, 1'b1, 4'd0);
        flush = 1'b1;
        #1;
        n_checks++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %0b want 0", disp_ready); end
        tick();
        flush      = 1'b0;
        disp_valid = 1'b0;
        n_checks++; if (occupancy !== 5'd0) begin n_fail++; $display("FAIL flush_occ0: got %0d want 0", occupancy); end
        n_checks++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL flush_iss: got %0b want 0", iss_valid); end
        wb_valid = 2'b11;
        wb_tag0  = 6'd60;
        wb_tag1  = 6'd62;
        tick();
        wb_valid = 2'b00;
        tick();
        n_checks++; if ({iss_valid, occupancy} !== {1'b0, 5'd0}) begin n_fail++; $display("FAIL flush_gone: got v=%0b occ=%0d want v=0 occ=0", iss_valid, occupancy); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            set_disp(7'b0110011, 6'(i), 6'(10 + i), 1'b0, 6'd0, 1'b1, 4'd0);
            tick();
        end
        n_checks++; if (occupancy !== 5'd16) begin n_fail++; $display("FAIL full_occ16: got %0d want 16", occupancy); end
        n_checks++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready0: got %0b want 0", disp_ready); end
        set_disp(7'b0110011, 6'd59, 6'd0, 1'b1, 6'd0, 1'b1, 4'd0);
        wb_valid = 2'b01;
        wb_tag0  = 6'd10;
        tick();
        wb_valid = 2'b00;
        n_checks++; if ({occupancy, disp_ready} !== {5'd16, 1'b0}) begin n_fail++; $display("FAIL full_held: got occ=%0d rdy=%0b want occ=16 rdy=0", occupancy, disp_ready); end
        tick();
        n_checks++; if ({iss_valid, iss_pd} !== {1'b1, 6'd0}) begin n_fail++; $display("FAIL full_issue_row0: got v=%0b pd=%0d want v=1 pd=0", iss_valid, iss_pd); end
        n_checks++; if ({occupancy, disp_ready} !== {5'd15, 1'b1}) begin n_fail++; $display("FAIL full_ready1: got occ=%0d rdy=%0b want occ=15 rdy=1", occupancy, disp_ready); end
        tick();
        disp_valid = 1'b0;
        n_checks++; if ({occupancy, iss_valid} !== {5'd16, 1'b0}) begin n_fail++; $display("FAIL full_17th_in: got occ=%0d v=%0b want occ=16 v=0", occupancy, iss_valid); end
        tick();
        n_checks++; if ({iss_valid, iss_pd, occupancy} !== {1'b1, 6'd59, 5'd15}) begin n_fail++; $display("FAIL full_17th_issue: got v=%0b pd=%0d occ=%0d want v=1 pd=59 occ=15", iss_valid, iss_pd, occupancy); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        set_disp(7'b0110011, 6'd11, 6'd0, 1'b1, 6'd0, 1'b1, 4'd0);
        tick();
        set_disp(7'b0110011, 6'd12, 6'd0, 1'b1, 6'd0, 1'b1, 4'd0);
        tick();
        disp_valid = 1'b0;
        n_checks++; if ({iss_valid, iss_pd, occupancy} !== {1'b1, 6'd11, 5'd1}) begin n_fail++; $display("FAIL rmid_before: got v=%0b pd=%0d occ=%0d want v=1 pd=11 occ=1", iss_valid, iss_pd, occupancy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({iss_valid, iss_pd, occupancy, disp_ready} !== {1'b0, 6'd0, 5'd0, 1'b0}) begin n_fail++; $display("FAIL rmid_async: got v=%0b pd=%0d occ=%0d rdy=%0b want all 0", iss_valid, iss_pd, occupancy, disp_ready); end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++; if ({iss_valid, occupancy} !== {1'b0, 5'd0}) begin n_fail++; $display("FAIL rmid_discard: got v=%0b occ=%0d want v=0 occ=0", iss_valid, occupancy); end
    endtask

    initial begin
        rst_n       = 1'b0;
        disp_valid  = 1'b0;
        disp_op     = '0;
        disp_pd     = '0;
        disp_ps1    = '0;
        disp_ps2    = '0;
        disp_rob    = '0;
        disp_s1_rdy = 1'b0;
        disp_s2_rdy = 1'b0;
        wb_valid    = '0;
        wb_tag0     = '0;
        wb_tag1     = '0;
        fu_busy     = '0;
        flush       = 1'b0;

        test_reset();
        test_basic();
        test_wakeup();
        test_same_cycle_wake();
        test_priority();
        test_flush();
        test_full();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
